// File: rtl/vram_arbiter.sv
// VRAM arbiter: schedules auto-refresh, video fetch and CPU accesses onto the SDRAM controller command port.
// Defining VRAM_ARB_STARVE_GUARD_EN adds a CPU starvation guard that bounds consecutive video grants.
module vram_arbiter #(
  parameter int REFRESH_CYCLES   = 810,
  parameter int CPU_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        vid_req,
  input  logic [21:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_rdata,
  output logic        vid_rvalid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_wdm,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_wdm,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy,
  output logic        ref_miss
);

  localparam int RCW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RCW-1:0] REF_LAST = RCW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_REF = 2'd0,
    OWN_VID = 2'd1,
    OWN_CPU = 2'd2
  } owner_t;

  state_t          state_q;
  owner_t          owner_q;
  logic            op_read_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic            mem_refresh_q;
  logic [21:0]     mem_addr_q;
  logic [15:0]     mem_din_q;
  logic [1:0]      mem_wdm_q;
  logic            vid_ack_q;
  logic            cpu_ack_q;
  logic            vid_rvalid_q;
  logic            cpu_rvalid_q;
  logic [15:0]     vid_rdata_q;
  logic [15:0]     cpu_rdata_q;

  logic [RCW-1:0]  ref_cnt_q;
  logic [RCW-1:0]  ref_cnt_d;
  logic            ref_pending_q;
  logic            ref_pending_d;
  logic            ref_miss_q;
  logic            ref_miss_d;
  logic            ref_tick_s;
  logic            ref_clear_s;

  logic            grant_ref_s;
  logic            grant_vid_s;
  logic            grant_cpu_s;
  logic            cpu_first_s;

  // Refresh timer next state; a grant retiring the pending refresh in the same cycle as a tick is not a miss
  always_comb begin
    ref_tick_s    = (ref_cnt_q == REF_LAST);
    ref_clear_s   = (state_q == ST_ISSUE) && mem_refresh_q;
    ref_pending_d = ref_pending_q;
    ref_miss_d    = ref_miss_q;
    if (ref_tick_s) begin
      ref_cnt_d     = {RCW{1'b0}};
      ref_pending_d = 1'b1;
      if (ref_pending_q && !ref_clear_s) begin
        ref_miss_d = 1'b1;
      end else begin
        ref_miss_d = ref_miss_q;
      end
    end else begin
      ref_cnt_d = ref_cnt_q + RCW'(1);
      if (ref_clear_s) begin
        ref_pending_d = 1'b0;
      end else begin
        ref_pending_d = ref_pending_q;
      end
    end
  end

  // Refresh timer, pending flag and sticky miss flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ref_cnt_q     <= {RCW{1'b0}};
      ref_pending_q <= 1'b0;
      ref_miss_q    <= 1'b0;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_miss_q    <= ref_miss_d;
    end
  end

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIMIT = 3'(CPU_STARVE_LIMIT);

  logic [2:0] starve_cnt_q;
  logic [2:0] starve_cnt_d;

  // Count video grants that overtook a waiting CPU request
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cpu_req || grant_cpu_s) begin
      starve_cnt_d = 3'd0;
    end else if (grant_vid_s) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= 3'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign cpu_first_s = (starve_cnt_q == STARVE_LIMIT);
`else
  assign cpu_first_s = 1'b0;
`endif

  // Grant selection; nothing is granted while the controller is busy
  always_comb begin
    grant_ref_s = 1'b0;
    grant_vid_s = 1'b0;
    grant_cpu_s = 1'b0;
    if ((state_q == ST_IDLE) && !mem_busy) begin
      if (ref_pending_q) begin
        grant_ref_s = 1'b1;
      end else if (cpu_req && cpu_first_s) begin
        grant_cpu_s = 1'b1;
      end else if (vid_req) begin
        grant_vid_s = 1'b1;
      end else if (cpu_req) begin
        grant_cpu_s = 1'b1;
      end else begin
        grant_ref_s = 1'b0;
      end
    end else begin
      grant_ref_s = 1'b0;
    end
  end

  // Command FSM with registered strobes, acks and read-data return
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_REF;
      op_read_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_refresh_q <= 1'b0;
      mem_addr_q    <= 22'd0;
      mem_din_q     <= 16'd0;
      mem_wdm_q     <= 2'b00;
      vid_ack_q     <= 1'b0;
      cpu_ack_q     <= 1'b0;
      vid_rvalid_q  <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      vid_rdata_q   <= 16'd0;
      cpu_rdata_q   <= 16'd0;
    end else begin
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_refresh_q <= 1'b0;
      vid_ack_q     <= 1'b0;
      cpu_ack_q     <= 1'b0;
      vid_rvalid_q  <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_ref_s) begin
            owner_q       <= OWN_REF;
            op_read_q     <= 1'b0;
            mem_refresh_q <= 1'b1;
            mem_addr_q    <= 22'd0;
            mem_din_q     <= 16'd0;
            mem_wdm_q     <= 2'b00;
            state_q       <= ST_ISSUE;
          end else if (grant_vid_s) begin
            owner_q    <= OWN_VID;
            op_read_q  <= 1'b1;
            mem_read_q <= 1'b1;
            vid_ack_q  <= 1'b1;
            mem_addr_q <= vid_addr;
            mem_din_q  <= 16'd0;
            mem_wdm_q  <= 2'b00;
            state_q    <= ST_ISSUE;
          end else if (grant_cpu_s) begin
            owner_q     <= OWN_CPU;
            op_read_q   <= !cpu_we;
            mem_read_q  <= !cpu_we;
            mem_write_q <= cpu_we;
            cpu_ack_q   <= 1'b1;
            mem_addr_q  <= cpu_addr;
            mem_din_q   <= cpu_we ? cpu_wdata : 16'd0;
            mem_wdm_q   <= cpu_we ? cpu_wdm : 2'b00;
            state_q     <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Operands stay on the bus until the controller drops busy
          if (!mem_busy) begin
            if (op_read_q && (owner_q == OWN_VID)) begin
              vid_rdata_q  <= mem_dout;
              vid_rvalid_q <= 1'b1;
            end else if (op_read_q && (owner_q == OWN_CPU)) begin
              cpu_rdata_q  <= mem_dout;
              cpu_rvalid_q <= 1'b1;
            end else begin
              vid_rvalid_q <= 1'b0;
            end
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_refresh = mem_refresh_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_wdm     = mem_wdm_q;
  assign vid_ack     = vid_ack_q;
  assign cpu_ack     = cpu_ack_q;
  assign vid_rvalid  = vid_rvalid_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign vid_rdata   = vid_rdata_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ref_miss    = ref_miss_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 4-cycle SDRAM controller model; honours VRAM_ARB_STARVE_GUARD_EN.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        vid_req = 1'b0;
  logic [21:0] vid_addr = 22'd0;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        vid_rvalid;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [21:0] cpu_addr = 22'd0;
  logic [15:0] cpu_wdata = 16'd0;
  logic [1:0]  cpu_wdm = 2'b00;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        mem_read;
  logic        mem_write;
  logic        mem_refresh;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_wdm;
  logic [15:0] mem_dout = 16'd0;
  logic        mem_busy;
  logic        ref_miss;

  logic        busy_force = 1'b1;
  int          busy_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [15:0] model_rdata = 16'd0;

  int vectors = 0;
  int miscompares = 0;

  vram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wdm(cpu_wdm), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wdm(mem_wdm),
    .mem_dout(mem_dout), .mem_busy(mem_busy), .ref_miss(ref_miss)
  );

  always #5 clk = ~clk;

  // Controller model: busy for 4 cycles after any strobe, read data appears as busy falls
  always @(posedge clk) begin
    if (mem_read || mem_write || mem_refresh) begin
      busy_cnt <= 4;
      rd_pend  <= mem_read;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1 && rd_pend) mem_dout <= model_rdata;
    end
  end

  assign mem_busy = busy_force | (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One isolated transaction: request in cycle 0, strobe/ack cycle 1, rvalid cycle 7
  task automatic run_op(input string tag, input bit cpu, input bit we, input logic [21:0] addr,
                        input logic [15:0] wdata, input logic [1:0] wdm, input logic [15:0] rdata);
    int bad;
    logic [17:0] exp_dw;
    logic [1:0]  rv_exp;
    exp_dw = we ? {wdata, wdm} : 18'd0;
    rv_exp = we ? 2'b00 : (cpu ? 2'b01 : 2'b10);
    model_rdata = rdata;
    if (cpu) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wdm = wdm;
    end else begin
      vid_req = 1'b1; vid_addr = addr;
    end
    cyc(1);
    check({tag, "_strobe"}, {29'd0, mem_read, mem_write, mem_refresh}, {29'd0, ~we, we, 1'b0});
    check({tag, "_ack"}, {30'd0, vid_ack, cpu_ack}, {30'd0, ~cpu, cpu});
    check({tag, "_addr"}, {10'd0, mem_addr}, {10'd0, addr});
    check({tag, "_din_wdm"}, {14'd0, mem_din, mem_wdm}, {14'd0, exp_dw});
    cpu_req = 1'b0;
    vid_req = 1'b0;
    bad = 0;
    for (int k = 2; k <= 6; k++) begin
      cyc(1);
      if (mem_read || mem_write || mem_refresh || vid_rvalid || cpu_rvalid || vid_ack || cpu_ack) bad++;
      if ({mem_din, mem_wdm} !== exp_dw || mem_addr !== addr) bad++;
    end
    check({tag, "_wait_hold"}, bad, 32'd0);
    cyc(1);
    check({tag, "_rvalid"}, {30'd0, vid_rvalid, cpu_rvalid}, {30'd0, rv_exp});
    if (!we) check({tag, "_rdata"}, {16'd0, (cpu ? cpu_rdata : vid_rdata)}, {16'd0, rdata});
    cyc(1);
    check({tag, "_rvalid_pulse"}, {30'd0, vid_rvalid, cpu_rvalid}, 32'd0);
  endtask

  initial begin
    int bad;
    int nr;
    int nv;
    int nc;
    int ng;
    int t;
    logic [11:0] seq;
    logic [1:0]  fifth;

    // Reset state
    cyc(3);
    check("rst_strobes", {29'd0, mem_read, mem_write, mem_refresh}, 32'd0);
    check("rst_acks_rvalid", {28'd0, vid_ack, cpu_ack, vid_rvalid, cpu_rvalid}, 32'd0);
    check("rst_addr", {10'd0, mem_addr}, 32'd0);
    check("rst_din_wdm", {14'd0, mem_din, mem_wdm}, 32'd0);
    check("rst_rdata", {vid_rdata, cpu_rdata}, 32'd0);
    check("rst_ref_miss", {31'd0, ref_miss}, 32'd0);

    // Controller initialisation: busy held, video request must be ignored
    resetn = 1'b1;
    vid_req = 1'b1;
    vid_addr = 22'h2A5A5;
    bad = 0;
    repeat (100) begin
      cyc(1);
      if (mem_read || mem_write || mem_refresh || vid_ack || cpu_ack) bad++;
    end
    check("init_quiet", bad, 32'd0);
    busy_force = 1'b0;
    run_op("init_vid", 1'b0, 1'b0, 22'h2A5A5, 16'd0, 2'b00, 16'h1234);

    cyc(2);
    run_op("cpu_rd", 1'b1, 1'b0, 22'h0123, 16'd0, 2'b00, 16'hBEEF);
    check("cpu_rd_vid_rdata_held", {16'd0, vid_rdata}, 32'h1234);

    cyc(2);
    run_op("cpu_wr", 1'b1, 1'b1, 22'h3ABCD, 16'h55AA, 2'b10, 16'hDEAD);
    check("cpu_wr_rdata_held", {16'd0, cpu_rdata}, 32'hBEEF);

    cyc(2);
    run_op("vid_rd2", 1'b0, 1'b0, 22'h00001, 16'd0, 2'b00, 16'hA5C3);
    check("vid_rd2_cpu_rdata_held", {16'd0, cpu_rdata}, 32'hBEEF);

    // Request withdrawn while busy leaves no trace
    cyc(2);
    busy_force = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h00777;
    cyc(5);
    cpu_req = 1'b0;
    busy_force = 1'b0;
    bad = 0;
    repeat (10) begin
      cyc(1);
      if (mem_read || mem_write || mem_refresh || vid_ack || cpu_ack) bad++;
    end
    check("cancel_no_side_effect", bad, 32'd0);

    // Priority: one refresh tick accumulates under busy, video and CPU waiting
    busy_force = 1'b1;
    vid_req = 1'b1; vid_addr = 22'h00ABC;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h00DEF;
    model_rdata = 16'h7777;
    bad = 0;
    repeat (810) begin
      cyc(1);
      if (mem_read || mem_write || mem_refresh || vid_ack || cpu_ack) bad++;
    end
    check("prio_busy_ignored", bad, 32'd0);
    check("prio_no_miss", {31'd0, ref_miss}, 32'd0);
    busy_force = 1'b0;
    seq = 12'd0; nr = 0; nv = 0; nc = 0;
    repeat (40) begin
      cyc(1);
      if (mem_refresh) begin seq = {seq[7:0], 4'h1}; nr++; end
      if (vid_ack) begin seq = {seq[7:0], 4'h2}; nv++; vid_req = 1'b0; end
      if (cpu_ack) begin seq = {seq[7:0], 4'h3}; nc++; cpu_req = 1'b0; end
    end
    check("prio_order", {20'd0, seq}, 32'h123);
    check("prio_counts", {nr[7:0], nv[7:0], nc[7:0]}, 32'h010101);
    check("prio_rdata", {vid_rdata, cpu_rdata}, 32'h77777777);

    // Refresh miss: two ticks while the controller stays busy
    busy_force = 1'b1;
    cyc(1620);
    check("miss_set", {31'd0, ref_miss}, 32'd1);
    busy_force = 1'b0;
    nr = 0; bad = 0;
    repeat (30) begin
      cyc(1);
      if (mem_refresh) nr++;
      if (mem_read || mem_write || vid_ack || cpu_ack) bad++;
    end
    check("miss_single_refresh", nr, 32'd1);
    check("miss_no_other", bad, 32'd0);
    check("miss_sticky", {31'd0, ref_miss}, 32'd1);

    // Continuous video load with a CPU write waiting
    vid_req = 1'b1; vid_addr = 22'h11111;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h22222; cpu_wdata = 16'hC0DE; cpu_wdm = 2'b00;
    ng = 0; nc = 0; t = 0; fifth = 2'd0;
    while (ng < 5 && t < 80) begin
      cyc(1);
      t++;
      if (vid_ack || cpu_ack) begin
        if (ng == 4) fifth = cpu_ack ? 2'd3 : 2'd2;
        if (cpu_ack) begin nc++; cpu_req = 1'b0; end
        ng++;
      end
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    check("starve_grants_seen", ng, 32'd5);
`ifdef VRAM_ARB_STARVE_GUARD_EN
    check("starve_fifth_is_cpu", {30'd0, fifth}, 32'd3);
    check("starve_cpu_grants", nc, 32'd1);
`else
    check("starve_fifth_is_vid", {30'd0, fifth}, 32'd2);
    check("starve_cpu_grants", nc, 32'd0);
`endif
    cyc(12);

    // Reset in the middle of a CPU read abandons it
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h00005;
    model_rdata = 16'h9999;
    cyc(1);
    check("midrst_ack", {31'd0, cpu_ack}, 32'd1);
    cpu_req = 1'b0;
    cyc(2);
    resetn = 1'b0;
    #1;
    check("midrst_outputs", {25'd0, mem_read, mem_write, mem_refresh, vid_ack, cpu_ack, vid_rvalid, cpu_rvalid}, 32'd0);
    check("midrst_regs", {cpu_rdata, 14'd0, mem_wdm}, 32'd0);
    check("midrst_ref_miss", {31'd0, ref_miss}, 32'd0);
    cyc(1);
    resetn = 1'b1;
    bad = 0;
    repeat (12) begin
      cyc(1);
      if (mem_read || mem_write || mem_refresh || vid_ack || cpu_ack || vid_rvalid || cpu_rvalid) bad++;
    end
    check("midrst_no_rvalid", bad, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
